// File: rtl/div_meas.sv
// Measures period and high time of a slow, asynchronous divided clock in units of clk
// cycles, and flags lock (stable repeated measurements) and loss of edges (timeout).
module div_meas #(
    parameter int CNT_W  = 8,
    parameter int LOCK_N = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_in,
    input  logic             en,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_cnt,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        MEAS_HIGH = 2'd2,
        MEAS_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]       LOCK_MAX = 4'(LOCK_N);

    state_t           state_q, state_d;
    logic             s1_q, s2_q, s3_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] h_lat_q, h_lat_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;
    logic [3:0]       lock_cnt_q, lock_cnt_d;

    logic             rise, fall;
    logic [CNT_W-1:0] cnt_inc;
    logic             pair_same;
    logic             cnt_full;

    assign rise      = s2_q & ~s3_q;
    assign fall      = ~s2_q & s3_q;
    assign cnt_full  = (cnt_q == CNT_MAX);
    // Saturating increment: the counter must never wrap back to a small value.
    assign cnt_inc   = cnt_full ? cnt_q : cnt_q + 1'b1;
    assign pair_same = (cnt_q == period_q) && (h_lat_q == high_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        h_lat_d    = h_lat_q;
        period_d   = period_q;
        high_d     = high_q;
        valid_d    = 1'b0;
        locked_d   = locked_q;
        timeout_d  = timeout_q;
        lock_cnt_d = lock_cnt_q;

        if (!en) begin
            // Disabling abandons any measurement in flight but keeps the last result.
            state_d    = IDLE;
            cnt_d      = '0;
            locked_d   = 1'b0;
            lock_cnt_d = '0;
            timeout_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = WAIT_RISE;
                end
                WAIT_RISE: begin
                    if (rise) begin
                        state_d = MEAS_HIGH;
                        cnt_d   = CNT_ONE;
                    end
                end
                MEAS_HIGH: begin
                    if (fall) begin
                        state_d = MEAS_LOW;
                        h_lat_d = cnt_q;
                        cnt_d   = cnt_inc;
                    end else if (cnt_full) begin
                        state_d    = WAIT_RISE;
                        cnt_d      = '0;
                        timeout_d  = 1'b1;
                        locked_d   = 1'b0;
                        lock_cnt_d = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                MEAS_LOW: begin
                    if (rise) begin
                        state_d  = MEAS_HIGH;
                        cnt_d    = CNT_ONE;
                        period_d = cnt_q;
                        high_d   = h_lat_q;
                        valid_d  = 1'b1;
                        if (pair_same)
                            lock_cnt_d = (lock_cnt_q >= LOCK_MAX) ? LOCK_MAX : lock_cnt_q + 4'd1;
                        else
                            lock_cnt_d = 4'd1;
                        locked_d = (lock_cnt_d >= LOCK_MAX);
                    end else if (cnt_full) begin
                        state_d    = WAIT_RISE;
                        cnt_d      = '0;
                        timeout_d  = 1'b1;
                        locked_d   = 1'b0;
                        lock_cnt_d = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            cnt_q      <= '0;
            h_lat_q    <= '0;
            period_q   <= '0;
            high_q     <= '0;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
            timeout_q  <= 1'b0;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            s1_q       <= clk_in;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            cnt_q      <= cnt_d;
            h_lat_q    <= h_lat_d;
            period_q   <= period_d;
            high_q     <= high_d;
            valid_q    <= valid_d;
            locked_q   <= locked_d;
            timeout_q  <= timeout_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    assign period     = period_q;
    assign high_cnt   = high_q;
    assign meas_valid = valid_q;
    assign locked     = locked_q;
    assign timeout    = timeout_q;

endmodule

// File: doc/div_meas.md
DIV_MEAS -- requirements
Module: div_meas

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the period and high-time counters and outputs.
REQ-002 SHALL have parameter LOCK_N, default 2: number of consecutive identical measurements required to assert locked (range 2..15).
REQ-003 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port clk_in, input, 1: divided clock under measurement, asynchronous to clk.
REQ-006 SHALL have port en, input, 1: measurement enable, level-sensitive.
REQ-007 SHALL have port period, output, CNT_W: last measured clk_in period in clk cycles.
REQ-008 SHALL have port high_cnt, output, CNT_W: last measured clk_in high time in clk cycles.
REQ-009 SHALL have port meas_valid, output, 1: one-cycle pulse when period/high_cnt update.
REQ-010 SHALL have port locked, output, 1: LOCK_N consecutive identical (period, high_cnt) pairs seen.
REQ-011 SHALL have port timeout, output, 1: sticky flag, clk_in edge missing for 2^CNT_W-1 cycles.

Function
REQ-012 SHALL synchronise clk_in through two flops (s1, s2), keep a third delayed copy s3; rise = s2 & ~s3, fall = ~s2 & s3.
REQ-013 SHALL implement FSM states IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW.
REQ-014 IDLE -> WAIT_RISE when en=1; any state -> IDLE when en=0 (that same cycle, locked cleared, period/high_cnt held).
REQ-015 WAIT_RISE -> MEAS_HIGH on rise; first rise only starts counting and produces no meas_valid.
REQ-016 MEAS_HIGH -> MEAS_LOW on fall; MEAS_LOW -> MEAS_HIGH on rise.
REQ-017 Counter cnt SHALL load 1 on every rise cycle, else increment by 1 each cycle in MEAS_HIGH/MEAS_LOW.
REQ-018 On fall in MEAS_HIGH, internal h_lat SHALL load cnt (cycles from rise inclusive to fall exclusive).
REQ-019 On rise in MEAS_LOW, period SHALL load cnt, high_cnt SHALL load h_lat, meas_valid SHALL pulse high on the next cycle (registered, one cycle).
REQ-020 Lock counter SHALL increment (saturating at LOCK_N) when a new pair equals the previous pair, reset to 1 when it differs; locked = (lock count >= LOCK_N), updated with meas_valid.
REQ-021 If cnt reaches 2^CNT_W-1 in MEAS_HIGH or MEAS_LOW without the expected edge: timeout SHALL set, locked clear, lock count clear, FSM -> WAIT_RISE, no meas_valid.
REQ-022 timeout SHALL stay set until rst or en falling to 0.
REQ-023 Simultaneous rise and en=0: en=0 wins, no meas_valid.
REQ-024 clk_in static (rise/fall never fire) in WAIT_RISE SHALL NOT set timeout.
REQ-025 cnt SHALL never wrap; saturation condition is REQ-021.

Reset
REQ-026 On rst=1 at a clk edge: FSM=IDLE, s1/s2/s3=0, cnt=0, h_lat=0, period=0, high_cnt=0, meas_valid=0, locked=0, timeout=0, lock count=0.
REQ-027 rst mid-measurement SHALL discard the partial measurement; first rise after release is again a start edge only.

Verification
REQ-028 en=1, clk_in high 2 / low 1 clk cycles, repeating -> first meas_valid after second detected rise, period=3, high_cnt=2; locked=1 with the second meas_valid (LOCK_N=2).
REQ-029 Locked at period=5/high=3, then switch to high 2 / low 2 -> next meas_valid period=4, high_cnt=2, locked=0; locked=1 again one valid later.
REQ-030 Locked, then clk_in stuck high for 300 cycles (CNT_W=8) -> timeout=1 after cnt hits 255, locked=0, no meas_valid; resume toggling -> measurements resume, timeout stays 1.
REQ-031 en deasserted mid-MEAS_LOW with rise same cycle -> no meas_valid, locked=0, period/high_cnt unchanged, timeout cleared.
REQ-032 rst asserted one cycle during MEAS_HIGH -> all outputs 0 next cycle; after release, first rise gives no meas_valid, second rise gives correct period.
REQ-033 clk_in held 0 for 1000 cycles after en=1 -> FSM stays WAIT_RISE, timeout=0, meas_valid never pulses.
